// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state encodings and tiling helper functions for matmul_sched
package matmul_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int row_size_mat_c(input int i_outer, input int block);
    return i_outer / block;
  endfunction
  function automatic int col_size_mat_c(input int w_outer, input int block);
    return w_outer / block;
  endfunction
  function automatic int max_flag(input int i_outer, input int w_outer, input int block);
    return row_size_mat_c(i_outer, block) * col_size_mat_c(w_outer, block);
  endfunction
  function automatic int k_steps(input int inner, input int block);
    return inner / block;
  endfunction
endpackage

// File: rtl/tile_counter.sv
// tile_counter: nested row/column/k counter with wrap flags for tile scheduling
module tile_counter import matmul_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int KS   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                k_inc,
  input  logic                rc_inc,
  output logic [cw(ROWS)-1:0] r,
  output logic [cw(COLS)-1:0] c,
  output logic [cw(KS)-1:0]   k,
  output logic                r_last,
  output logic                c_last,
  output logic                k_last
);
  localparam int RW = cw(ROWS);
  localparam int CW = cw(COLS);
  localparam int KW = cw(KS);
  assign r_last = r == RW'(ROWS - 1);
  assign c_last = c == CW'(COLS - 1);
  assign k_last = k == KW'(KS - 1);
  // k steps within a tile; c advances per tile and carries into r
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r <= '0;
      c <= '0;
      k <= '0;
    end else begin
      if (k_inc) k <= k_last ? '0 : k + 1'b1;
      if (rc_inc) begin
        c <= c_last ? '0 : c + 1'b1;
        if (c_last) r <= r_last ? '0 : r + 1'b1;
      end
    end
  end
endmodule

// File: rtl/matmul_sched.sv
// matmul_sched: tile scheduler driving BRAM reads, systolic MAC enables and output writes
module matmul_sched import matmul_pkg::*; #(
  parameter int BLOCK_SIZE        = 2,
  parameter int INNER_DIMENSION   = 8,
  parameter int I_OUTER_DIMENSION = 16,
  parameter int W_OUTER_DIMENSION = 16,
  parameter int PIPE_LAT          = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        ready,
  output logic        done,
  output logic [13:0] in_addrb,
  output logic [11:0] wb_addrb,
  output logic        rd_en,
  output logic        mac_en,
  output logic        mac_first,
  output logic        out_wea,
  output logic [cw(max_flag(I_OUTER_DIMENSION, W_OUTER_DIMENSION, BLOCK_SIZE))-1:0] out_addra
);
  localparam int ROW_SIZE_MAT_C = row_size_mat_c(I_OUTER_DIMENSION, BLOCK_SIZE);
  localparam int COL_SIZE_MAT_C = col_size_mat_c(W_OUTER_DIMENSION, BLOCK_SIZE);
  localparam int MAX_FLAG       = max_flag(I_OUTER_DIMENSION, W_OUTER_DIMENSION, BLOCK_SIZE);
  localparam int K_STEPS        = k_steps(INNER_DIMENSION, BLOCK_SIZE);
  localparam int AW             = cw(MAX_FLAG);
  localparam int DW             = cw(PIPE_LAT);
  logic [2:0]                     state;
  logic [2:0]                     state_nxt;
  logic [DW-1:0]                  drain;
  logic                           drain_last;
  logic                           clr;
  logic                           k_inc;
  logic                           rc_inc;
  logic                           r_last;
  logic                           c_last;
  logic                           k_last;
  logic [cw(ROW_SIZE_MAT_C)-1:0]  r;
  logic [cw(COL_SIZE_MAT_C)-1:0]  c;
  logic [cw(K_STEPS)-1:0]         k;
  logic                           mac_en_q;
  logic                           mac_first_q;
  tile_counter #(
    .ROWS (ROW_SIZE_MAT_C),
    .COLS (COL_SIZE_MAT_C),
    .KS   (K_STEPS)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst_n),
    .clr    (clr),
    .k_inc  (k_inc),
    .rc_inc (rc_inc),
    .r      (r),
    .c      (c),
    .k      (k),
    .r_last (r_last),
    .c_last (c_last),
    .k_last (k_last)
  );
  assign ready      = state == S_IDLE;
  assign done       = state == S_DONE;
  assign rd_en      = state == S_LOAD;
  assign out_wea    = state == S_WRITE;
  assign mac_en     = mac_en_q;
  assign mac_first  = mac_first_q;
  assign in_addrb   = rd_en ? 14'(32'(r) * K_STEPS + 32'(k)) : '0;
  assign wb_addrb   = rd_en ? 12'(32'(c) * K_STEPS + 32'(k)) : '0;
  assign out_addra  = out_wea ? AW'(32'(r) * COL_SIZE_MAT_C + 32'(c)) : '0;
  assign drain_last = drain == DW'(PIPE_LAT - 1);
  assign clr        = abort && !ready;
  assign k_inc      = rd_en && !clr;
  assign rc_inc     = out_wea && !clr;
  // abort out of any active state wins over every normal transition
  always_comb begin
    state_nxt = clr              ? S_IDLE :
                state == S_IDLE  ? (start ? S_LOAD : S_IDLE) :
                state == S_LOAD  ? (k_last ? S_DRAIN : S_LOAD) :
                state == S_DRAIN ? (drain_last ? S_WRITE : S_DRAIN) :
                state == S_WRITE ? (r_last && c_last ? S_DONE : S_LOAD) :
                S_IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst_n) state <= S_IDLE;
    else state <= state_nxt;
  end
  // drain cycle count, restarted every time DRAIN is entered
  always_ff @(posedge clk) begin
    if (rst_n || state != S_DRAIN) drain <= '0;
    else drain <= drain + 1'b1;
  end
  // mac controls lag reads by the one-cycle BRAM latency; abort kills the tail
  always_ff @(posedge clk) begin
    if (rst_n || abort) begin
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
    end else begin
      mac_en_q    <= rd_en;
      mac_first_q <= rd_en && k == '0;
    end
  end
endmodule

// File: doc/matmul_sched.md
MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 2: systolic array dimension (N x N).
REQ-002 SHALL have parameter INNER_DIMENSION, default 8: shared dimension of the input and weight matrices.
REQ-003 SHALL have parameter I_OUTER_DIMENSION, default 16: input-matrix rows.
REQ-004 SHALL have parameter W_OUTER_DIMENSION, default 16: weight-matrix columns.
REQ-005 SHALL have parameter PIPE_LAT, default 3, range >= 1: cycles from the last mac_en to the last valid accumulator.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-007 SHALL have port rst_n, input, 1: synchronous reset, active-high (1 = reset despite the suffix).
REQ-008 SHALL have port start, input, 1: begins a full matrix product when sampled in IDLE.
REQ-009 SHALL have port abort, input, 1: cancels the run in progress.
REQ-010 SHALL have port ready, output, 1: high only in IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse on completion.
REQ-012 SHALL have port in_addrb, output, 14: input-BRAM read address.
REQ-013 SHALL have port wb_addrb, output, 12: weight-BRAM read address.
REQ-014 SHALL have port rd_en, output, 1: BRAM read enable for both BRAMs.
REQ-015 SHALL have port mac_en, output, 1: systolic array accumulate enable.
REQ-016 SHALL have port mac_first, output, 1: the accumulator loads rather than adds.
REQ-017 SHALL have port out_wea, output, 1: output-BRAM write strobe.
REQ-018 SHALL have port out_addra, output, log2(MAX_FLAG): output-BRAM write address.

Function
REQ-019 SHALL derive the following constants:
- ROW_SIZE_MAT_C = I_OUTER_DIMENSION/BLOCK_SIZE
- COL_SIZE_MAT_C = W_OUTER_DIMENSION/BLOCK_SIZE
- MAX_FLAG = ROW_SIZE_MAT_C*COL_SIZE_MAT_C
- K_STEPS = INNER_DIMENSION/BLOCK_SIZE
REQ-020 SHALL implement states IDLE, LOAD, DRAIN, WRITE and DONE.
REQ-021 SHALL transition IDLE->LOAD on start=1; start in any other state SHALL be ignored.
REQ-022 SHALL hold LOAD for exactly K_STEPS cycles with rd_en=1 and k=0..K_STEPS-1.
REQ-023 SHALL drive in_addrb = r*K_STEPS+k and wb_addrb = c*K_STEPS+k, both zero-extended.
REQ-024 SHALL drive mac_en as rd_en delayed 1 cycle (BRAM latency) and mac_first as (LOAD and k==0) delayed 1 cycle.
REQ-025 SHALL hold DRAIN for exactly PIPE_LAT cycles, then enter WRITE for exactly 1 cycle with out_wea=1 and out_addra = r*COL_SIZE_MAT_C+c.
REQ-026 SHALL leave WRITE by advancing c, wrapping c at COL_SIZE_MAT_C-1 to 0 and incrementing r, then entering LOAD; when r and c are both at their maximum it SHALL enter DONE.
REQ-027 SHALL assert done=1 in DONE for one cycle, then return to IDLE.
REQ-028 SHALL take K_STEPS+PIPE_LAT+1 cycles per tile; with defaults, done is high 513 cycles after the start edge.
REQ-029 SHALL force abort=1 in any non-IDLE state to IDLE on the next edge with no done, no out_wea, and r, c and k cleared; abort has priority over every other transition.
REQ-030 SHALL deassert rd_en, mac_en, mac_first and out_wea outside the states named above, except for the one-cycle mac_en/mac_first tail.
REQ-031 SHALL clear the delayed mac_en tail on abort.

Reset
REQ-032 SHALL, while rst_n=1 at an edge, force state=IDLE, r=c=k=0, and drive ready=1 with all other outputs 0 on the next cycle.
REQ-033 SHALL give rst_n priority over abort and start, and a reset mid-run SHALL produce no done and no further write.

Structure
REQ-034 SHALL place the derived constants and the state enumeration in a shared package, matmul_pkg.
REQ-035 SHALL use one sub-module, tile_counter, a parameterized nested r/c/k counter with wrap flags; the FSM and delay registers reside in matmul_sched.

Verification
REQ-036 SHALL cover, with defaults and PIPE_LAT=3: start pulse -> first rd_en with in_addrb=0 and wb_addrb=0 one cycle later, mac_first the cycle after that, done 513 cycles after start.
REQ-037 SHALL cover a full run: 64 out_wea pulses, out_addra 0..63 in order, and tile (r=1,c=2) reading in_addrb 4..7 and wb_addrb 8..11.
REQ-038 SHALL cover start asserted continuously during a run -> exactly one done, with a second run starting only after ready=1.
REQ-039 SHALL cover abort in the DRAIN of tile 5 -> ready=1 next cycle, no out_wea for address 5, no done.
REQ-040 SHALL cover rst_n=1 for 1 cycle in mid-LOAD -> all outputs 0 and ready=1 next cycle; a following start restarts at address 0.
REQ-041 SHALL cover BLOCK_SIZE=2, INNER_DIMENSION=2, I_OUTER_DIMENSION=2, W_OUTER_DIMENSION=2 -> single tile, K_STEPS=1, done 6 cycles after start.
